// File: rtl/button_pkg.sv
// Shared types and elaboration helpers for the pushbutton event bank.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HOLD,
        RELEASE_WAIT
    } btn_state_t;

    // Clock cycles per 1 ms tick.
    function automatic int unsigned ms_ticks(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: 2-FF synchroniser, symmetric debounce FSM, hold/long-press
// and auto-repeat timers. All timers advance on the shared 1 ms tick.
module button_event_channel
    import button_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned LONG_MS         = 1000,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    input  logic repeat_en,
    output logic held,
    output logic press,
    output logic release_p,
    output logic click,
    output logic long_press,
    output logic repeat_p
);

    localparam int unsigned DB_W   = cnt_width(DEBOUNCE_MS);
    localparam int unsigned HOLD_W = cnt_width(LONG_MS);
    localparam int unsigned REP_W  = cnt_width(max2(REPEAT_DELAY_MS, REPEAT_RATE_MS));

    btn_state_t        state;
    logic              sync1;
    logic              sync2;
    logic              p;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              rep_armed;
    logic              long_done;

    assign p = sync2 ^ ACTIVE_LOW;

    // Sync flops reset to the idle pin level so reset never fakes a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= ACTIVE_LOW;
            sync2      <= ACTIVE_LOW;
            state      <= IDLE;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            rep_armed  <= 1'b0;
            long_done  <= 1'b0;
            held       <= 1'b0;
            press      <= 1'b0;
            release_p  <= 1'b0;
            click      <= 1'b0;
            long_press <= 1'b0;
            repeat_p   <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            press      <= 1'b0;
            release_p  <= 1'b0;
            click      <= 1'b0;
            long_press <= 1'b0;
            repeat_p   <= 1'b0;

            // Hold and repeat timers run for the whole debounced hold, bounces included.
            if (state == HOLD || state == RELEASE_WAIT) begin
                if (tick && hold_cnt != HOLD_W'(LONG_MS)) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(LONG_MS - 1)) begin
                        long_press <= 1'b1;
                        long_done  <= 1'b1;
                    end
                end
                if (!repeat_en) begin
                    rep_cnt   <= '0;
                    rep_armed <= 1'b0;
                end else if (tick) begin
                    if (rep_cnt == (rep_armed ? REP_W'(REPEAT_RATE_MS - 1)
                                              : REP_W'(REPEAT_DELAY_MS - 1))) begin
                        repeat_p  <= 1'b1;
                        rep_cnt   <= '0;
                        rep_armed <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (p) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                            state     <= HOLD;
                            held      <= 1'b1;
                            press     <= 1'b1;
                            hold_cnt  <= '0;
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
                            long_done <= 1'b0;
                        end else begin
                            db_cnt <= db_cnt + DB_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!p) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state <= HOLD;
                    end else if (tick) begin
                        if (db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                            state     <= IDLE;
                            held      <= 1'b0;
                            release_p <= 1'b1;
                            click     <= ~long_done;
                        end else begin
                            db_cnt <= db_cnt + DB_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_event_bank.sv
// N-channel pushbutton front end: shared 1 ms prescaler feeding independent
// debounce/classification channels.
module button_event_bank
    import button_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned LONG_MS         = 1000,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] click,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p
);

    localparam int unsigned TICK_DIV = ms_ticks(CLK_HZ);
    localparam int unsigned DIV_W    = cnt_width(TICK_DIV - 1);

    if (CLK_HZ % 1000 != 0 || CLK_HZ < 1000) begin : g_bad_clk
        $error("button_event_bank: CLK_HZ must be a non-zero multiple of 1000");
    end
    if (DEBOUNCE_MS < 1 || LONG_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_bad_ms
        $error("button_event_bank: all *_MS parameters must be >= 1");
    end
    if (DEBOUNCE_MS >= LONG_MS) begin : g_bad_long
        $error("button_event_bank: DEBOUNCE_MS must be less than LONG_MS");
    end

    logic tick;

    // Shared ms prescaler; a 1 kHz clock ticks every cycle.
    if (TICK_DIV == 1) begin : g_no_div
        assign tick = 1'b1;
    end else begin : g_div
        logic [DIV_W-1:0] div_cnt;
        assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                div_cnt <= '0;
            end else if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        button_event_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .LONG_MS         (LONG_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .raw        (raw[i]),
            .repeat_en  (repeat_en[i]),
            .held       (held[i]),
            .press      (press[i]),
            .release_p  (release_p[i]),
            .click      (click[i]),
            .long_press (long_press[i]),
            .repeat_p   (repeat_p[i])
        );
    end

endmodule

// File: tb/tb_button_event_bank.sv
// Bench for button_event_bank: table-driven ch0 scenarios, hand-written corner
// sequences, and randomized multi-channel traffic against a run-length reference model.
module tb_button_event_bank;

    localparam int NC    = 4;
    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int DELAY = 8;
    localparam int RATE  = 3;
    localparam int LAT   = 7;   // raw drive -> press visible: 2 sync + 1 entry + DEB

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] raw;
    logic [NC-1:0] repeat_en;
    logic [NC-1:0] held, press, release_p, click, long_press, repeat_p;

    button_event_bank #(
        .N_CH(NC), .CLK_HZ(1000), .ACTIVE_LOW(1'b1), .DEBOUNCE_MS(DEB),
        .LONG_MS(LONG), .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw(raw), .repeat_en(repeat_en),
        .held(held), .press(press), .release_p(release_p), .click(click),
        .long_press(long_press), .repeat_p(repeat_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mdl_en = 1'b0;

    // Reference model: held flips after DEB+1 consecutive samples disagreeing with it;
    // hold time and repeat-enabled run length are plain counters since the press.
    int d1[NC], d2[NC], run[NC], hold_ms[NC], en_run[NC];
    bit ld[NC];
    logic [NC-1:0] m_held, m_press, m_rel, m_click, m_long, m_rep;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                d1[c] = 0; d2[c] = 0; run[c] = 0; hold_ms[c] = 0; en_run[c] = 0; ld[c] = 1'b0;
            end
            m_held = '0; m_press = '0; m_rel = '0; m_click = '0; m_long = '0; m_rep = '0;
        end else begin
            m_press = '0; m_rel = '0; m_click = '0; m_long = '0; m_rep = '0;
            for (int c = 0; c < NC; c++) begin
                int  pv;
                bit  ld_old;
                pv     = d2[c];
                d2[c]  = d1[c];
                d1[c]  = (raw[c] == 1'b0) ? 1 : 0;
                ld_old = ld[c];
                if (m_held[c]) begin
                    hold_ms[c]++;
                    if (hold_ms[c] == LONG) begin
                        m_long[c] = 1'b1;
                        ld[c] = 1'b1;
                    end
                    if (repeat_en[c]) begin
                        en_run[c]++;
                        if (en_run[c] == DELAY || (en_run[c] > DELAY && (en_run[c] - DELAY) % RATE == 0))
                            m_rep[c] = 1'b1;
                    end else begin
                        en_run[c] = 0;
                    end
                end
                run[c] = (pv != int'(m_held[c])) ? run[c] + 1 : 0;
                if (run[c] == DEB + 1) begin
                    run[c] = 0;
                    if (!m_held[c]) begin
                        m_held[c] = 1'b1; m_press[c] = 1'b1;
                        hold_ms[c] = 0; en_run[c] = 0; ld[c] = 1'b0;
                    end else begin
                        m_held[c] = 1'b0; m_rel[c] = 1'b1; m_click[c] = ~ld_old;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (mdl_en) begin
            checks++;
            if ({held, press, release_p, click, long_press, repeat_p} !==
                {m_held, m_press, m_rel, m_click, m_long, m_rep}) begin
                errors++;
                $display("FAIL model t=%0t held/press/rel/click/long/rep got=%h_%h_%h_%h_%h_%h exp=%h_%h_%h_%h_%h_%h",
                         $time, held, press, release_p, click, long_press, repeat_p,
                         m_held, m_press, m_rel, m_click, m_long, m_rep);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-step ch0 event bookkeeping for the directed scenarios.
    int k;
    int n_p, n_r, n_c, n_l, n_rep, n_both;
    int t_p, t_r, t_c, t_l;

    task automatic clear_counts();
        k = 0; n_p = 0; n_r = 0; n_c = 0; n_l = 0; n_rep = 0; n_both = 0;
        t_p = -1; t_r = -1; t_c = -1; t_l = -1;
    endtask

    task automatic step(input bit pr, input bit ren);
        @(negedge clk);
        if (press[0])      begin n_p++; if (t_p < 0) t_p = k; end
        if (release_p[0])  begin n_r++; if (t_r < 0) t_r = k; end
        if (click[0])      begin n_c++; if (t_c < 0) t_c = k; end
        if (long_press[0]) begin n_l++; if (t_l < 0) t_l = k; end
        if (repeat_p[0])   n_rep++;
        if (long_press[0] && repeat_p[0]) n_both++;
        raw[0]       = pr ? 1'b0 : 1'b1;
        repeat_en[0] = ren;
        k++;
    endtask

    typedef struct {
        int hold;
        bit ren;
        int e_press, e_rel, e_click, e_long, e_rep, e_both;
    } vec_t;

    vec_t vecs[6];
    int   seg_left[NC];
    bit   cur[NC];

    initial begin
        rst_n = 1'b0; raw = '1; repeat_en = '0;
        vecs[0] = '{10, 1'b0, 1, 1, 1, 0, 0, 0};  // short click
        vecs[1] = '{30, 1'b0, 1, 1, 0, 1, 0, 0};  // long press, no click
        vecs[2] = '{22, 1'b1, 1, 1, 0, 1, 5, 1};  // repeats at 8,11,14,17,20
        vecs[3] = '{15, 1'b1, 1, 1, 1, 0, 3, 0};  // repeats at 8,11,14
        vecs[4] = '{ 4, 1'b0, 0, 0, 0, 0, 0, 0};  // shorter than debounce
        vecs[5] = '{ 5, 1'b0, 1, 1, 1, 0, 0, 0};  // just long enough
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({held, press, release_p, click, long_press, repeat_p}), 0);
        rst_n = 1'b1;
        mdl_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            clear_counts();
            for (int i = 0; i < vecs[v].hold; i++) step(1'b1, vecs[v].ren);
            for (int i = 0; i < 20; i++)           step(1'b0, vecs[v].ren);
            step(1'b0, 1'b0);
            chk($sformatf("vec%0d press_cnt", v),   n_p,    vecs[v].e_press);
            chk($sformatf("vec%0d release_cnt", v), n_r,    vecs[v].e_rel);
            chk($sformatf("vec%0d click_cnt", v),   n_c,    vecs[v].e_click);
            chk($sformatf("vec%0d long_cnt", v),    n_l,    vecs[v].e_long);
            chk($sformatf("vec%0d repeat_cnt", v),  n_rep,  vecs[v].e_rep);
            chk($sformatf("vec%0d long_rep_same", v), n_both, vecs[v].e_both);
            chk($sformatf("vec%0d press_time", v),   t_p, vecs[v].e_press ? LAT : -1);
            chk($sformatf("vec%0d release_time", v), t_r, vecs[v].e_rel ? vecs[v].hold + LAT : -1);
            chk($sformatf("vec%0d click_time", v),   t_c, vecs[v].e_click ? vecs[v].hold + LAT : -1);
        end

        // Contact bounce: 2-cycle toggles, steady press from step 12.
        clear_counts();
        for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        chk("bounce press_cnt", n_p, 1);
        chk("bounce press_time", t_p, 12 + LAT);
        chk("bounce release_cnt", n_r, 1);

        // Release bounce: a 1-cycle re-press inside the release debounce must not reset hold time.
        clear_counts();
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        chk("relbounce press_cnt", n_p, 1);
        chk("relbounce release_cnt", n_r, 1);
        chk("relbounce long_cnt", n_l, 1);
        chk("relbounce click_cnt", n_c, 0);
        chk("relbounce long_time", t_l, 27);
        chk("relbounce release_time", t_r, 28);

        // Reset mid-hold with the button still down.
        clear_counts();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        chk("midhold held_before_reset", int'(held[0]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midhold outputs_in_reset", int'({held, press, release_p, click, long_press, repeat_p}), 0);
        repeat (3) @(negedge clk);
        clear_counts();
        rst_n = 1'b1;
        k = 1;
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        chk("midhold repress_cnt", n_p, 1);
        chk("midhold repress_time", t_p, LAT);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        // Randomized traffic on all channels, checked every cycle by the model.
        for (int c = 0; c < NC; c++) begin seg_left[c] = 0; cur[c] = 1'b0; end
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            if (cyc == 1200) rst_n = 1'b0;
            if (cyc == 1203) rst_n = 1'b1;
            for (int c = 0; c < NC; c++) begin
                if (seg_left[c] == 0) begin
                    cur[c] = ~cur[c];
                    seg_left[c] = cur[c] ? int'($urandom_range(1, 35)) : int'($urandom_range(1, 12));
                end
                seg_left[c]--;
                raw[c] = ~cur[c];
                if ($urandom_range(0, 39) == 0) repeat_en[c] = ~repeat_en[c];
            end
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
